// File: rtl/cla_operand_gen.sv
// -----------------------------------------------------------------------------
// cla_operand_gen
//
// Operand generator for the 16-bit add/sub CLA datapath. Two Fibonacci LFSRs
// produce ain/bin operand pairs, and an add_sub control is derived from
// op_mode. Each vector is offered over a valid/ready handshake, and a run
// issues NUM_VEC vectors before a one-cycle done pulse.
//
// Optional feature (compile-time macro CLA_GEN_MISR_EN):
//   When this macro is defined, a 16-bit MISR compacts sum_in/cout_in on every
//   transfer into signature. When it is undefined, signature is tied to 0 and
//   sum_in/cout_in are ignored.
//
// Parameters:
//   NUM_VEC  vectors per run (1..65535)
//   SEED_A   reset/fallback seed for LFSR A
//   SEED_B   reset/fallback seed for LFSR B
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a run (IDLE only)
//   seed_load         capture seed_a/seed_b into the seed registers (IDLE only)
//   seed_a, seed_b    seed values; a zero value falls back to SEED_A/SEED_B
//   op_mode           00 add, 01 sub, 10 alternate, 11 random (lfsr_b[0])
//   ready             downstream accepts the current vector
//   valid             ain/bin/add_sub carry a vector
//   ain, bin          operands, straight from LFSR A / LFSR B
//   cin               constant 0
//   add_sub           1 = subtract
//   busy              high while in RUN
//   done              one-cycle pulse after the last transfer
//   vec_cnt           vectors transferred in the current/last run
//   sum_in, cout_in   adder response to the presented operands (MISR input)
//   signature         MISR value (0 when the MISR is not built)
// -----------------------------------------------------------------------------
module cla_operand_gen #(
    parameter int unsigned NUM_VEC = 256,
    parameter logic [15:0] SEED_A  = 16'hACE1,
    parameter logic [15:0] SEED_B  = 16'h1D2B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed_a,
    input  logic [15:0] seed_b,
    input  logic [1:0]  op_mode,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] ain,
    output logic [15:0] bin,
    output logic        cin,
    output logic        add_sub,
    output logic        busy,
    output logic        done,
    output logic [15:0] vec_cnt,
    input  logic [15:0] sum_in,
    input  logic        cout_in,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Count value held just before the final transfer of a run.
    localparam logic [15:0] LAST_CNT = 16'(NUM_VEC - 1);

    // x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_a_next(input logic [15:0] a);
        return {a[14:0], a[15] ^ a[13] ^ a[12] ^ a[10]};
    endfunction

    // x^16+x^15+x^13+x^4+1
    function automatic logic [15:0] lfsr_b_next(input logic [15:0] b);
        return {b[14:0], b[15] ^ b[14] ^ b[12] ^ b[3]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] seed_a_q, seed_a_d;
    logic [15:0] seed_b_q, seed_b_d;
    logic [15:0] lfsr_a_q, lfsr_a_d;
    logic [15:0] lfsr_b_q, lfsr_b_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic        tog_q, tog_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] seed_a_eff;
    logic [15:0] seed_b_eff;
    logic        run_start;
    logic        xfer;

    // Zero seeds would lock the LFSRs, so substitute the parameter value.
    assign seed_a_eff = (seed_a == 16'h0000) ? SEED_A : seed_a;
    assign seed_b_eff = (seed_b == 16'h0000) ? SEED_B : seed_b;

    assign run_start = (state_q == ST_IDLE) && start;
    assign xfer      = valid_q && ready;

    always_comb begin
        state_d   = state_q;
        seed_a_d  = seed_a_q;
        seed_b_d  = seed_b_q;
        lfsr_a_d  = lfsr_a_q;
        lfsr_b_d  = lfsr_b_q;
        vec_cnt_d = vec_cnt_q;
        tog_d     = tog_q;

        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    seed_a_d = seed_a_eff;
                    seed_b_d = seed_b_eff;
                end
                if (start) begin
                    // A simultaneous seed_load takes effect for this run.
                    lfsr_a_d  = seed_load ? seed_a_eff : seed_a_q;
                    lfsr_b_d  = seed_load ? seed_b_eff : seed_b_q;
                    vec_cnt_d = 16'h0000;
                    tog_d     = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ready) begin
                    lfsr_a_d  = lfsr_a_next(lfsr_a_q);
                    lfsr_b_d  = lfsr_b_next(lfsr_b_q);
                    vec_cnt_d = vec_cnt_q + 16'd1;
                    tog_d     = ~tog_q;
                    if (vec_cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/status outputs are registered off the next state.
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seed_a_q  <= SEED_A;
            seed_b_q  <= SEED_B;
            lfsr_a_q  <= SEED_A;
            lfsr_b_q  <= SEED_B;
            vec_cnt_q <= 16'h0000;
            tog_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_a_q  <= seed_a_d;
            seed_b_q  <= seed_b_d;
            lfsr_a_q  <= lfsr_a_d;
            lfsr_b_q  <= lfsr_b_d;
            vec_cnt_q <= vec_cnt_d;
            tog_q     <= tog_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // add_sub follows op_mode combinationally; the other sources are flops,
    // so it stays stable across a stall as long as op_mode is held.
    always_comb begin
        add_sub = 1'b0;
        case (op_mode)
            2'b00: add_sub = 1'b0;
            2'b01: add_sub = 1'b1;
            2'b10: add_sub = tog_q;
            2'b11: add_sub = lfsr_b_q[0];
            default: add_sub = 1'b0;
        endcase
    end

    assign valid   = valid_q;
    assign ain     = lfsr_a_q;
    assign bin     = lfsr_b_q;
    assign cin     = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign vec_cnt = vec_cnt_q;

`ifdef CLA_GEN_MISR_EN
    logic [15:0] sig_q, sig_d;

    // The MISR shares LFSR A's polynomial. It samples the adder in the transfer
    // cycle itself, so the adder is assumed to respond within that cycle.
    always_comb begin
        sig_d = sig_q;
        if (run_start) begin
            sig_d = 16'h0000;
        end else if (xfer) begin
            sig_d = lfsr_a_next(sig_q) ^ sum_in ^ {15'b0, cout_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    // Adder response is not observed without the MISR; fold it into a sink.
    logic unused_misr_in;
    logic unused_misr_ctl;
    assign unused_misr_in  = ^{sum_in, cout_in};
    assign unused_misr_ctl = run_start ^ xfer;
    assign signature       = 16'h0000;
`endif

endmodule

// File: tb/tb_cla_operand_gen.sv
// -----------------------------------------------------------------------------
// tb_cla_operand_gen
//
// Directed bench for cla_operand_gen built with NUM_VEC = 4. The expected
// operand sequences are hand-computed from the LFSR polynomials. A golden
// add/sub adder drives sum_in/cout_in. Each transfer prints one line.
// -----------------------------------------------------------------------------
module tb_cla_operand_gen;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_a;
    logic [15:0] seed_b;
    logic [1:0]  op_mode;
    logic        ready;
    logic        valid;
    logic [15:0] ain;
    logic [15:0] bin;
    logic        cin;
    logic        add_sub;
    logic        busy;
    logic        done;
    logic [15:0] vec_cnt;
    logic [15:0] sum_in;
    logic        cout_in;
    logic [15:0] signature;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_a [NV];
    logic [15:0] exp_b [NV];
    logic        exp_as[NV];

    always #5 clk = ~clk;

    cla_operand_gen #(
        .NUM_VEC (NV),
        .SEED_A  (16'hACE1),
        .SEED_B  (16'h1D2B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_load (seed_load),
        .seed_a    (seed_a),
        .seed_b    (seed_b),
        .op_mode   (op_mode),
        .ready     (ready),
        .valid     (valid),
        .ain       (ain),
        .bin       (bin),
        .cin       (cin),
        .add_sub   (add_sub),
        .busy      (busy),
        .done      (done),
        .vec_cnt   (vec_cnt),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .signature (signature)
    );

    // Golden adder: subtract is ain + ~bin + 1.
    always_comb begin
        if (add_sub) {cout_in, sum_in} = {1'b0, ain} + {1'b0, ~bin} + 17'd1;
        else         {cout_in, sum_in} = {1'b0, ain} + {1'b0, bin};
    end

    function automatic logic [15:0] misr_step(input logic [15:0] s,
                                              input logic [15:0] sm,
                                              input logic        co);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ sm ^ {15'b0, co};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_exp_a_default();
        exp_a[0] = 16'hACE1; exp_a[1] = 16'h59C3; exp_a[2] = 16'hB387; exp_a[3] = 16'h670F;
    endtask

    // rmode: 0 ready high, 1 ready toggling, 2 five-cycle stall mid-run.
    task automatic run_vectors(input string tag, input logic [1:0] op,
                               input int rmode, input bit load_at_start, input bit poke);
        int          k = 0;
        int          done_cycles = 0;
        bit          finished = 0;
        logic [15:0] msig = 16'h0000;
        logic [15:0] exp_sig;

        op_mode = op;
        @(negedge clk);
        start     = 1'b1;
        seed_load = load_at_start;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = cyc[0];
                default: ready = !(cyc >= 2 && cyc < 7);
            endcase
            // Seed load and start mid-run must both be ignored.
            if (poke && cyc == 1) begin
                seed_load = 1'b1; start = 1'b1; seed_a = 16'hFFFF; seed_b = 16'hFFFF;
            end else begin
                seed_load = 1'b0; start = 1'b0;
            end
            if (valid) begin
                if (k < NV) begin
                    check($sformatf("%s_ain%0d", tag, k), ain, exp_a[k]);
                    check($sformatf("%s_bin%0d", tag, k), bin, exp_b[k]);
                    check($sformatf("%s_as%0d", tag, k), add_sub, exp_as[k]);
                    check($sformatf("%s_cnt%0d", tag, k), vec_cnt, k);
                end else begin
                    check($sformatf("%s_extra_valid", tag), 1, 0);
                end
                check($sformatf("%s_busy", tag), busy, 1);
            end
            if (valid && ready) begin
                msig = misr_step(msig, sum_in, cout_in);
                $display("%s xfer %0d ain=%h bin=%h add_sub=%b sum=%h cout=%b",
                         tag, k, ain, bin, add_sub, sum_in, cout_in);
                k++;
            end
            if (done) begin
                done_cycles++;
                check($sformatf("%s_valid_in_done", tag), valid, 0);
            end else if (done_cycles > 0) begin
                finished = 1;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        start = 1'b0;
        seed_load = 1'b0;
        check($sformatf("%s_finished", tag), finished, 1);
        check($sformatf("%s_xfers", tag), k, NV);
        check($sformatf("%s_done_width", tag), done_cycles, 1);
        check($sformatf("%s_final_cnt", tag), vec_cnt, NV);
        check($sformatf("%s_busy_after", tag), busy, 0);
        check($sformatf("%s_valid_after", tag), valid, 0);
`ifdef CLA_GEN_MISR_EN
        exp_sig = msig;
`else
        exp_sig = 16'h0000;
`endif
        check($sformatf("%s_signature", tag), signature, exp_sig);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; seed_load = 1'b0;
        seed_a = 16'h0000; seed_b = 16'h0000; op_mode = 2'b00; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec_cnt", vec_cnt, 0);
        check("rst_signature", signature, 0);
        check("rst_ain", ain, 16'hACE1);
        check("rst_bin", bin, 16'h1D2B);
        check("cin_zero", cin, 0);

        set_exp_a_default();
        exp_b[0] = 16'h1D2B; exp_b[1] = 16'h3A56; exp_b[2] = 16'h74AD; exp_b[3] = 16'hE95B;

        exp_as[0] = 0; exp_as[1] = 0; exp_as[2] = 0; exp_as[3] = 0;
        run_vectors("add", 2'b00, 0, 0, 0);
        run_vectors("stall", 2'b00, 2, 0, 0);

        exp_as[0] = 0; exp_as[1] = 1; exp_as[2] = 0; exp_as[3] = 1;
        run_vectors("alt", 2'b10, 1, 0, 0);

        exp_as[0] = 1; exp_as[1] = 0; exp_as[2] = 1; exp_as[3] = 1;
        run_vectors("rand", 2'b11, 0, 0, 0);

        exp_as[0] = 1; exp_as[1] = 1; exp_as[2] = 1; exp_as[3] = 1;
        run_vectors("sub", 2'b01, 0, 0, 0);

        // Zero seed_a falls back to ACE1; seed_b 1234 is used directly.
        seed_a = 16'h0000; seed_b = 16'h1234;
        exp_b[0] = 16'h1234; exp_b[1] = 16'h2469; exp_b[2] = 16'h48D3; exp_b[3] = 16'h91A7;
        exp_as[0] = 0; exp_as[1] = 0; exp_as[2] = 0; exp_as[3] = 0;
        run_vectors("seed", 2'b00, 0, 1, 1);
        run_vectors("seed_kept", 2'b00, 0, 0, 0);

        // Reset in the middle of a run.
        op_mode = 2'b00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check("mid_cnt_before_rst", vec_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vec_cnt", vec_cnt, 0);
        check("mid_rst_signature", signature, 0);
        check("mid_rst_ain", ain, 16'hACE1);
        check("mid_rst_bin", bin, 16'h1D2B);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || valid) done_seen++;
            @(negedge clk);
        end
        check("mid_rst_no_done", done_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
